// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches under a credit limit and
// buffers returned words in a DEPTH-entry FIFO. Optional macro FETCH_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int END_ADDR = 144
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic        stall_in,
  input  logic        flush,
  input  logic [7:0]  flush_pc,
  output logic [31:0] instr_out,
  output logic [7:0]  pc_out,
  output logic        out_valid,
  output logic        full,
  output logic        done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [8:0] END_A = 9'(END_ADDR);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic [7:0]      fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [7:0]      infl_pc_q, infl_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [7:0]      fifo_pc_q    [DEPTH];

  logic [CW-1:0]   occupancy;
  logic [8:0]      next_pc_ext;
  logic            credit_ok, pc_ok, issue, fifo_vld, enq, deq, byp_take;

  // Credit counts queued plus in-flight words, never the same-cycle dequeue,
  // so a response always has a free slot waiting for it.
  always_comb begin
    occupancy   = count_q + CW'(inflight_q);
    credit_ok   = occupancy < CW'(DEPTH);
    pc_ok       = {1'b0, fetch_pc_q} < END_A;
    next_pc_ext = {1'b0, fetch_pc_q} + 9'd4;
    issue       = (state_q == S_RUN) && !flush && credit_ok && pc_ok;
    fifo_vld    = (count_q != '0);
  end

`ifdef FETCH_BYPASS_EN
  logic bypass;
  always_comb begin
    bypass   = (count_q == '0) && inflight_q;
    byp_take = bypass && !stall_in && !flush;
  end

  always_comb begin
    out_valid = fifo_vld || bypass;
    instr_out = '0;
    pc_out    = '0;
    if (fifo_vld) begin
      instr_out = fifo_instr_q[head_q];
      pc_out    = fifo_pc_q[head_q];
    end else if (bypass) begin
      instr_out = mem_data;
      pc_out    = infl_pc_q;
    end
  end
`else
  always_comb begin
    byp_take  = 1'b0;
    out_valid = fifo_vld;
    instr_out = fifo_vld ? fifo_instr_q[head_q] : '0;
    pc_out    = fifo_vld ? fifo_pc_q[head_q]    : '0;
  end
`endif

  always_comb begin
    enq        = inflight_q && !flush && !byp_take;
    deq        = fifo_vld && !stall_in && !flush;
    inflight_d = issue;
    infl_pc_d  = issue ? fetch_pc_q : infl_pc_q;
    if (flush) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = flush_pc;
    end else begin
      count_d    = count_q + CW'(enq) - CW'(deq);
      head_d     = head_q + PW'(deq);
      tail_d     = tail_q + PW'(enq);
      fetch_pc_d = issue ? next_pc_ext[7:0] : fetch_pc_q;
    end
  end

  assign mem_addr = fetch_pc_q;
  assign full     = (count_q == CW'(DEPTH));
  assign done     = (state_q == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (flush) begin
        state_q <= ({1'b0, flush_pc} < END_A) ? S_RUN : S_DRAIN;
      end else begin
        case (state_q)
          S_RUN:   if (!pc_ok || (issue && next_pc_ext >= END_A)) state_q <= S_DRAIN;
          S_DRAIN: if (count_d == '0 && !inflight_d) state_q <= S_DONE;
          default: state_q <= S_DONE;
        endcase
      end
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    infl_pc_q <= infl_pc_d;
    if (enq) begin
      fifo_instr_q[tail_q] <= mem_data;
      fifo_pc_q[tail_q]    <= infl_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: default instance plus an END_ADDR=16 instance,
// each fed by a one-cycle-latency instruction memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_in, flush;
  logic [7:0]  flush_pc, mem_addr, pc_out;
  logic [31:0] mem_data, instr_out;
  logic        out_valid, full, done;

  logic        rst_e, e_stall, e_flush;
  logic [7:0]  e_fpc, e_mem_addr, e_pc;
  logic [31:0] e_mem_data, e_instr;
  logic        e_valid, e_full, e_done;

  int          vectors = 0;
  int          miscompares = 0;
  int          delivered;
  logic [7:0]  exp_pc;

`ifdef FETCH_BYPASS_EN
  localparam int E_LAST = 5;
`else
  localparam int E_LAST = 6;
`endif

  fetch_queue u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .stall_in(stall_in), .flush(flush), .flush_pc(flush_pc),
    .instr_out(instr_out), .pc_out(pc_out), .out_valid(out_valid),
    .full(full), .done(done)
  );

  fetch_queue #(.DEPTH(4), .END_ADDR(16)) u_end (
    .clk(clk), .rst(rst_e), .mem_addr(e_mem_addr), .mem_data(e_mem_data),
    .stall_in(e_stall), .flush(e_flush), .flush_pc(e_fpc),
    .instr_out(e_instr), .pc_out(e_pc), .out_valid(e_valid),
    .full(e_full), .done(e_done)
  );

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return {8'hA5, ~a, 8'h5A, a};
  endfunction

  always @(posedge clk) begin
    mem_data   <= word_of(mem_addr);
    e_mem_data <= word_of(e_mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: no stall, 1: stall held, 2: stall on odd cycles
  task automatic watch(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      stall_in = (mode == 1) ? 1'b1 : (mode == 2) ? i[0] : 1'b0;
      if (out_valid) begin
        chk("pc_order", pc_out, exp_pc);
        chk("instr_word", instr_out, word_of(exp_pc));
        if (!stall_in) begin
          exp_pc = exp_pc + 8'd4;
          delivered++;
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; rst_e = 1'b1; stall_in = 1'b0; flush = 1'b0; flush_pc = '0;
    e_stall = 1'b0; e_flush = 1'b0; e_fpc = '0;
    exp_pc = '0; delivered = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);

    // Reset release: cycle 0 issues PC 0
    rst = 1'b0;
    chk("c0_valid", out_valid, 0);
    chk("c0_addr", mem_addr, 0);
    tick();
    chk("c1_addr", mem_addr, 8'd4);
`ifndef FETCH_BYPASS_EN
    chk("c1_valid", out_valid, 0);
    tick();
`endif
    chk("first_valid", out_valid, 1);
    chk("first_pc", pc_out, 0);
    watch(10, 0);
    chk("stream_cnt", delivered, 10);

    // Long stall: queue fills to DEPTH, fetching stops
    watch(10, 1);
    chk("stall_full", full, 1);
    chk("stall_head", pc_out, exp_pc);
    chk("stall_addr", mem_addr, exp_pc + 8'd16);
    delivered = 0;
    watch(12, 0);
    chk("release_cnt", delivered >= 8, 1);

    // Restart at 0, then alternate stall across several wraps
    stall_in = 1'b0; flush = 1'b1; flush_pc = 8'h00;
    tick();
    flush = 1'b0;
    chk("flush0_valid", out_valid, 0);
    exp_pc = 8'h00; delivered = 0;
    watch(40, 2);
    chk("alt_cnt", delivered >= 12, 1);

    // Fill, then asynchronous reset in mid-cycle
    watch(8, 1);
    chk("pre_rst_full", full, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pc", pc_out, 0);
    chk("arst_instr", instr_out, 0);
    chk("arst_full", full, 0);
    chk("arst_addr", mem_addr, 0);
    tick();
    rst = 1'b0;
    stall_in = 1'b1;
    repeat (4) tick();
    // Three entries queued, one in flight
    chk("preflush_valid", out_valid, 1);
    chk("preflush_pc", pc_out, 0);
    chk("preflush_full", full, 0);
    flush = 1'b1; flush_pc = 8'h40;
    tick();
    flush = 1'b0; stall_in = 1'b0;
    chk("postflush_valid", out_valid, 0);
    chk("postflush_addr", mem_addr, 8'h40);
    tick();
    exp_pc = 8'h40; delivered = 0;
`ifndef FETCH_BYPASS_EN
    chk("flush_lat_valid", out_valid, 0);
    tick();
`endif
    chk("redirect_valid", out_valid, 1);
    chk("redirect_pc", pc_out, 8'h40);
    watch(6, 0);
    chk("redirect_cnt", delivered, 6);

    // END_ADDR=16 instance: exactly four instructions, then done
    @(posedge clk);
    #1;
    rst_e = 1'b0;
    exp_pc = 8'h00; delivered = 0;
    for (int i = 0; i < E_LAST; i++) begin
      if (e_valid) begin
        chk("end_pc", e_pc, exp_pc);
        chk("end_instr", e_instr, word_of(exp_pc));
        exp_pc = exp_pc + 8'd4;
        delivered++;
      end
      if (i == E_LAST - 1) chk("end_done_early", e_done, 0);
      tick();
    end
    chk("end_done", e_done, 1);
    chk("end_cnt", delivered, 4);
    chk("end_valid", e_valid, 0);
    chk("end_addr", e_mem_addr, 8'd16);
    repeat (5) tick();
    chk("end_done_hold", e_done, 1);
    chk("end_addr_hold", e_mem_addr, 8'd16);
    chk("end_pc_zero", e_pc, 0);
    chk("end_full", e_full, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
